// File: rtl/lzs_copy_engine.sv
// rtl/lzs_copy_engine.sv - LZS token decoder: literal/copy expansion against an external history RAM
//
// Purpose: accepts literal and copy tokens, expands copies byte by byte by
// reading back the sliding-window history, emits every decoded byte on a
// valid/ready stream and writes that byte into the history RAM as it leaves.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-low reset
//   hist_clr                  pulse: empty the history and abort any token in flight
//   tok_valid/tok_ready       token handshake
//   tok_copy, tok_lit         token kind, literal byte
//   tok_off, tok_len          copy offset (1..2047) and length (1..255)
//   de_hraddr, de_hdata       history read address / read data (one-cycle latency)
//   de_hwaddr, de_hwe, de_data history write port
//   out_valid/out_ready, out_data  decoded byte stream
//   busy, err                 not idle / sticky bad-token flag
module lzs_copy_engine (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        hist_clr,
  input  logic        tok_valid,
  output logic        tok_ready,
  input  logic        tok_copy,
  input  logic [7:0]  tok_lit,
  input  logic [10:0] tok_off,
  input  logic [7:0]  tok_len,
  output logic [10:0] de_hraddr,
  output logic [10:0] de_hwaddr,
  output logic        de_hwe,
  output logic [7:0]  de_data,
  input  logic [7:0]  de_hdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, RD, DATA, EMIT} state_t;

  state_t      state;
  logic [10:0] wp;
  logic [10:0] off;
  logic [11:0] fill;
  logic [7:0]  rem;

  logic accept;
  logic bad_copy;
  logic handshake;

  assign tok_ready = (state == IDLE) & ~hist_clr;
  assign accept    = tok_valid & tok_ready;
  // A copy may only reach back into bytes that actually exist in this block.
  assign bad_copy  = (tok_off == 11'd0) || ({1'b0, tok_off} > fill) || (tok_len == 8'd0);
  // out_valid is only ever set in EMIT, so this is the EMIT handshake.
  assign handshake = out_valid & out_ready;

  // The byte is committed to history on the very cycle it leaves; a clear
  // on that cycle suppresses the write along with everything else.
  assign de_hwe    = handshake & ~hist_clr;
  assign de_hwaddr = wp;
  assign de_data   = out_data;
  assign busy      = (state != IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state     <= IDLE;
      wp        <= 11'd0;
      fill      <= 12'd0;
      rem       <= 8'd0;
      off       <= 11'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      de_hraddr <= 11'd0;
      err       <= 1'b0;
    end else if (hist_clr) begin
      state     <= IDLE;
      wp        <= 11'd0;
      fill      <= 12'd0;
      rem       <= 8'd0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (!tok_copy) begin
              out_data  <= tok_lit;
              rem       <= 8'd1;
              out_valid <= 1'b1;
              state     <= EMIT;
            end else if (bad_copy) begin
              // Swallow the token: no output, no history update.
              err <= 1'b1;
            end else begin
              off       <= tok_off;
              rem       <= tok_len;
              // Read address is prepared here so it is already on the bus in RD.
              de_hraddr <= wp - tok_off;
              state     <= RD;
            end
          end
        end
        RD: begin
          state <= DATA;
        end
        DATA: begin
          out_data  <= de_hdata;
          out_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            wp        <= wp + 11'd1;
            if (fill != 12'd2048) fill <= fill + 12'd1;
            rem <= rem - 8'd1;
            if (rem != 8'd1) begin
              // Next read is relative to the advanced pointer, so a byte
              // written this cycle is visible to an overlapping copy.
              de_hraddr <= wp + 11'd1 - off;
              state     <= RD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
